// File: rtl/riscv_ctrl_pkg.sv
// Purpose : shared types and constants for the multi-cycle RV32I subset controller.
// Latency : n/a (types, constants and helpers only).
// Backpressure : n/a.
// Contents: FSM state enum, ALU op codes, opcode/funct fields, instruction class enum,
//           decode record and a branch-class helper.
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_FAULT  = 3'd5
    } state_e;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_WORD    = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BLT     = 3'b100;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_BEQ     = 3'd3,
        CLS_BLT     = 3'd4,
        CLS_ILLEGAL = 3'd5
    } iclass_e;

    typedef struct packed {
        iclass_e    cls;
        logic [3:0] alu_op;
        logic       alu_src;
    } dec_t;

    localparam dec_t DEC_CLEAR = '{cls: CLS_ALU, alu_op: ALU_AND, alu_src: 1'b0};

    function automatic logic is_branch(input iclass_e cls);
        return (cls == CLS_BEQ) || (cls == CLS_BLT);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Purpose : bundle of controller <-> datapath/memory signals.
// Latency : n/a (wiring only).
// Backpressure : memory stalls the controller by holding mem_ready low.
// master = controller (drives enables), slave = datapath + shared memory port.
interface multicycle_ctrl_if;
    logic [31:0] instruction;
    logic        zero;
    logic        lt;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        i_or_d;
    logic        ir_write;
    logic        pc_write;
    logic        pc_src;
    logic        reg_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic [3:0]  alu_op;
    logic [2:0]  state;
    logic        fault;

    modport master (
        input  instruction, zero, lt, mem_ready,
        output mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src,
               reg_write, mem_to_reg, alu_src, alu_op, state, fault
    );

    modport slave (
        output instruction, zero, lt, mem_ready,
        input  mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src,
               reg_write, mem_to_reg, alu_src, alu_op, state, fault
    );
endinterface

// File: rtl/instr_decoder.sv
// Purpose : classify an RV32I instruction word into {class, alu_op, alu_src}.
// Latency : combinational, 0 cycles.
// Backpressure : none.
// Ports: instr_i = instruction word, dec_o = decode record (CLS_ILLEGAL if unsupported).
module instr_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [31:0] instr_i,
    output dec_t        dec_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    // Register indices and immediates belong to the datapath, not to control.
    assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

    always_comb begin
        dec_o = '{cls: CLS_ILLEGAL, alu_op: ALU_AND, alu_src: 1'b0};
        case (opcode)
            OPC_RTYPE: begin
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        F3_ADD_SUB: dec_o = '{cls: CLS_ALU, alu_op: ALU_ADD, alu_src: 1'b0};
                        F3_OR:      dec_o = '{cls: CLS_ALU, alu_op: ALU_OR,  alu_src: 1'b0};
                        F3_AND:     dec_o = '{cls: CLS_ALU, alu_op: ALU_AND, alu_src: 1'b0};
                        default:    ;
                    endcase
                end else if (funct7 == F7_SUB && funct3 == F3_ADD_SUB) begin
                    dec_o = '{cls: CLS_ALU, alu_op: ALU_SUB, alu_src: 1'b0};
                end
            end
            OPC_ITYPE: begin
                if (funct3 == F3_ADD_SUB)
                    dec_o = '{cls: CLS_ALU, alu_op: ALU_ADD, alu_src: 1'b1};
                else if (funct3 == F3_OR)
                    dec_o = '{cls: CLS_ALU, alu_op: ALU_OR, alu_src: 1'b1};
            end
            OPC_LUI:
                dec_o = '{cls: CLS_ALU, alu_op: ALU_LUI, alu_src: 1'b1};
            OPC_LOAD: begin
                if (funct3 == F3_WORD)
                    dec_o = '{cls: CLS_LOAD, alu_op: ALU_ADD, alu_src: 1'b1};
            end
            OPC_STORE: begin
                if (funct3 == F3_WORD)
                    dec_o = '{cls: CLS_STORE, alu_op: ALU_ADD, alu_src: 1'b1};
            end
            OPC_BRANCH: begin
                if (funct3 == F3_BEQ)
                    dec_o = '{cls: CLS_BEQ, alu_op: ALU_SUB, alu_src: 1'b0};
                else if (funct3 == F3_BLT)
                    dec_o = '{cls: CLS_BLT, alu_op: ALU_SUB, alu_src: 1'b0};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Purpose : FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I subset, sticky FAULT on error.
// Latency : branch 3, ALU/sw 4, lw 5 cycles with zero-wait memory; +1 per memory wait cycle.
// Backpressure : mem_req held until mem_ready; a wait of TIMEOUT+1 cycles (TIMEOUT>0) faults.
// Ports: clk, rst (sync, active-high); bus = master side of multicycle_ctrl_if
//        (instruction/zero/lt/mem_ready in; memory handshake, datapath enables, state, fault out).
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
);

    // A zero TIMEOUT disables the check but still needs a legal 1-bit counter.
    localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    dec_t          dec_q, dec_d;
    dec_t          dec_w;
    logic          waiting;
    logic          timed_out;
    logic          br_taken;

    instr_decoder u_dec (
        .instr_i (bus.instruction),
        .dec_o   (dec_w)
    );

    // Only FETCH and MEM issue requests, so only they can wait on memory.
    assign waiting   = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !bus.mem_ready;
    // mem_ready in the limit cycle completes normally because waiting is then 0.
    assign timed_out = (TIMEOUT != 0) && waiting && (cnt_q == CNT_LIMIT);
    assign br_taken  = ((dec_q.cls == CLS_BEQ) && bus.zero) ||
                       ((dec_q.cls == CLS_BLT) && bus.lt);

    always_comb begin
        state_d = state_q;
        dec_d   = dec_q;
        // The counter is zero whenever FETCH or MEM is entered, since both are
        // only left on mem_ready (counter cleared) or into FAULT.
        if (waiting)
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        else
            cnt_d = '0;

        case (state_q)
            ST_FETCH: begin
                if (bus.mem_ready)  state_d = ST_DECODE;
                else if (timed_out) state_d = ST_FAULT;
            end
            ST_DECODE: begin
                // IR is sampled here only; later changes cannot alter this instruction.
                dec_d   = dec_w;
                state_d = (dec_w.cls == CLS_ILLEGAL) ? ST_FAULT : ST_EXEC;
            end
            ST_EXEC: begin
                if (is_branch(dec_q.cls))
                    state_d = ST_FETCH;
                else if (dec_q.cls == CLS_LOAD || dec_q.cls == CLS_STORE)
                    state_d = ST_MEM;
                else if (dec_q.cls == CLS_ALU)
                    state_d = ST_WB;
                else
                    state_d = ST_FAULT;
            end
            ST_MEM: begin
                if (bus.mem_ready)
                    state_d = (dec_q.cls == CLS_STORE) ? ST_FETCH : ST_WB;
                else if (timed_out)
                    state_d = ST_FAULT;
            end
            ST_WB:    state_d = ST_FETCH;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            cnt_q   <= '0;
            dec_q   <= DEC_CLEAR;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
        end
    end

    // Controls are combinational so the memory handshake completes in the
    // cycle mem_ready is seen. Reset gates everything, aborting a pending store.
    always_comb begin
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.i_or_d     = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_src     = 1'b0;
        bus.reg_write  = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src    = 1'b0;
        bus.alu_op     = ALU_AND;
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    bus.mem_req = 1'b1;
                    if (bus.mem_ready) begin
                        bus.ir_write = 1'b1;
                        bus.pc_write = 1'b1;
                    end
                end
                ST_EXEC: begin
                    bus.alu_op  = dec_q.alu_op;
                    bus.alu_src = dec_q.alu_src;
                    if (is_branch(dec_q.cls) && br_taken) begin
                        bus.pc_write = 1'b1;
                        bus.pc_src   = 1'b1;
                    end
                end
                ST_MEM: begin
                    // Address and strobe depend on state and decode only: stable all request.
                    bus.mem_req = 1'b1;
                    bus.i_or_d  = 1'b1;
                    bus.mem_we  = (dec_q.cls == CLS_STORE);
                    bus.alu_op  = ALU_ADD;
                    bus.alu_src = 1'b1;
                end
                ST_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = (dec_q.cls == CLS_LOAD);
                    bus.alu_op     = dec_q.alu_op;
                    bus.alu_src    = dec_q.alu_src;
                end
                default: ;
            endcase
        end
    end

    assign bus.state = state_q;
    assign bus.fault = (state_q == ST_FAULT);

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencing controller for the RV32I subset the CPU supports: and, or, add, sub, addi, ori, lui, lw, sw, beq, blt. It replaces single-cycle control with a FETCH/DECODE/EXEC/MEM/WB state machine. It drives the datapath enables and ALU selection, and handshakes with a single shared instruction/data memory port. Any unsupported encoding, or a memory timeout, parks the controller in a sticky FAULT state.

## Interface
- TIMEOUT, 15: maximum memory wait cycles before FAULT; 0 disables the timeout.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- instruction  in  32  current IR contents from the datapath.
- zero  in  1  ALU result == 0.
- lt  in  1  ALU signed rs1 < rs2.
- mem_ready  in  1  memory has completed the request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  write strobe, valid with mem_req.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALU result.
- ir_write  out  1  load IR from memory read data.
- pc_write  out  1  update PC.
- pc_src  out  1  PC source: 0 = PC+4, 1 = branch target.
- reg_write  out  1  register file write.
- mem_to_reg  out  1  write-back source: 1 = memory data.
- alu_src  out  1  ALU B operand: 1 = immediate.
- alu_op  out  4  ALU function.
- state  out  3  current state, for debug.
- fault  out  1  sticky fault flag.

## Operation
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=5.
- ALU op encodings: AND=0000, OR=0001, ADD=0010, LUI pass-immediate=0100, SUB=0110.
- FETCH: mem_req=1, i_or_d=0, mem_we=0.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
- DECODE: classify instruction; the class and alu_op are latched into a decode register at the edge.
  - Illegal encoding: go to FAULT.
  - Otherwise: go to EXEC.
  - After DECODE, changes on instruction are ignored until the next FETCH.
- EXEC: drive alu_op and alu_src from the decode register.
  - ALU ops (and/or/add/sub/addi/ori/lui): go to WB.
  - lw/sw: alu_op=ADD, alu_src=1, go to MEM.
  - beq: taken iff zero. blt: taken iff lt. Branch ALU op is SUB, alu_src=0.
  - Taken branch: pc_write=1, pc_src=1. Not taken: pc_write=0. Either way, go to FETCH.
- MEM: mem_req=1, i_or_d=1, mem_we=1 for sw only; alu_op=ADD and alu_src=1 are held.
  - On mem_ready: sw goes to FETCH, lw goes to WB.
- WB: reg_write=1 for one cycle; mem_to_reg=1 for lw only; ALU inputs are held. Go to FETCH.
- FAULT: fault=1 and every enable is 0. Only rst exits FAULT.
- Wait counter (width clog2(TIMEOUT+1)):
  - Cleared on entry to FETCH or MEM; increments each cycle waited without mem_ready.
  - If counter==TIMEOUT and mem_ready=0, the next state is FAULT.
  - mem_ready in that same cycle wins.
- Outputs are combinational from state, the decode register, mem_ready, zero and lt. Undriven outputs are 0.

## Timing
- Reset: while rst=1, every enable output and mem_req are forced to 0. The next edge sets state=FETCH, fault=0, counter=0 and clears the decode register.
- Reset mid-operation (including MEM with a store pending) aborts with no write.
- Latency with zero-wait memory: branch 3 cycles, ALU op and sw 4 cycles, lw 5 cycles. Each memory wait cycle adds 1.
- Memory handshake:
  - mem_req is held until the cycle mem_ready=1 is sampled; mem_ready without mem_req is ignored.
  - Address and write strobe are stable for the whole request.
- ir_write, pc_write and reg_write are single-cycle pulses. No state asserts two write enables to the same resource.

## Structure
- Package riscv_ctrl_pkg: state enum, ALU op constants, opcode/funct3/funct7 constants, instruction-class enum (ALU, LOAD, STORE, BEQ, BLT, ILLEGAL).
- Sub-module instr_decoder: combinational mapping instruction to {class, alu_op, alu_src}.
- multicycle_ctrl holds the FSM, wait counter, decode register and output logic.

## Test plan
- add x3,x1,x2 (0x002081B3), mem_ready tied 1 -> state 0,1,2,4,0; reg_write=1 only in WB; alu_op=0010, alu_src=0 in EXEC.
- lw x5,8(x0) (0x00802283), mem_ready low 3 cycles in MEM -> MEM lasts 4 cycles with mem_req=1, i_or_d=1, mem_we=0; then WB with reg_write=1, mem_to_reg=1.
- beq x1,x2,+8 (0x00208463):
  - zero=1 -> EXEC has pc_write=1, pc_src=1, alu_op=0110.
  - zero=0 -> pc_write=0.
  - Either way, next state is FETCH.
- sw with rst asserted during MEM -> mem_we=0 and mem_req=0 that cycle; state=FETCH after the edge; the memory model records no write.
- Illegal instruction 0x00000000 -> DECODE then FAULT; fault=1 and all enables 0 for 20 cycles; rst returns to FETCH with fault=0.
- TIMEOUT=4, mem_ready held 0 in FETCH -> 5 FETCH cycles, then FAULT. Repeat with mem_ready=1 on the 5th cycle -> DECODE, no fault.
